// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter:
// FSM states, store-type encodings and byte-enable patterns.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_IFETCH = 2'd2,
        S_DDONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/ready bus between the arbiter (master) and the unified memory (slave).
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_be_gen.sv
// Byte-enable and write-lane replication for data accesses; reads and
// word/unknown store types use the full word unchanged.
module mem_be_gen
    import mem_arb_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes
);

    always_comb begin
        be = BE_ALL;
        if (write) begin
            case (store_type)
                ST_HALF: be = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                ST_BYTE: be = BE_BYTE0 << addr_lo;
                default: be = BE_ALL;
            endcase
        end
    end

    // Each lane picks its source byte so the enabled lane always carries the store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lanes[gi*8 +: 8] =
                (write && store_type == ST_BYTE) ? wdata[7:0] :
                (write && store_type == ST_HALF) ? wdata[(gi%2)*8 +: 8] :
                                                   wdata[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data accesses beat instruction fetches, no preemption.
// Optional forced completion on a stuck memory when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic                      if_valid,
    output logic [31:0]               if_rdata,
    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_wdata,
    input  logic [1:0]                d_store_type,
    output logic                      d_done,
    output logic [31:0]               d_rdata,
    output logic                      stall_o,
    mem_port_arbiter_if.master        mem,
    output logic                      timeout_err
);

`ifdef MEM_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255;
`endif

    arb_state_t  state_reg;
    logic        mem_req_reg, mem_we_reg;
    logic [31:0] mem_addr_reg, mem_wdata_reg;
    logic [3:0]  mem_be_reg;
    logic        if_valid_reg, d_done_reg;
    logic [31:0] if_rdata_reg, d_rdata_reg;

    logic        d_access;
    logic        timeout_hit;
    logic        access_done;
    logic [31:0] rdata_in;
    logic [3:0]  be_gen;
    logic [31:0] wdata_gen;

    wire unused_if_addr_lo = ^if_addr[1:0];

    assign d_access = d_read | d_write;

    mem_be_gen u_be_gen (
        .store_type  (d_store_type),
        .addr_lo     (d_addr[1:0]),
        .write       (d_write),
        .wdata       (d_wdata),
        .be          (be_gen),
        .wdata_lanes (wdata_gen)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             timeout_err_reg;
    logic             in_access;

    assign in_access   = (state_reg == S_DATA) || (state_reg == S_IFETCH);
    // Fires in the last allowed wait cycle so mem_req stays up exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = in_access && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg <= in_access ? wait_cnt_reg + CNT_W'(1) : '0;
            if (timeout_hit && !mem.mem_ready)
                timeout_err_reg <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign access_done = mem.mem_ready | timeout_hit;
    assign rdata_in    = mem.mem_ready ? mem.mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            if_valid_reg  <= 1'b0;
            d_done_reg    <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            if_valid_reg <= 1'b0;
            d_done_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (d_access) begin
                        state_reg     <= S_DATA;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= d_write;
                        mem_addr_reg  <= {d_addr[31:2], 2'b00};
                        mem_be_reg    <= be_gen;
                        mem_wdata_reg <= wdata_gen;
                    end else if (if_req) begin
                        state_reg     <= S_IFETCH;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= {if_addr[31:2], 2'b00};
                        mem_be_reg    <= BE_ALL;
                        mem_wdata_reg <= '0;
                    end
                end
                S_DATA: begin
                    if (access_done) begin
                        if (!mem_we_reg)
                            d_rdata_reg <= rdata_in;
                        mem_req_reg <= 1'b0;
                        d_done_reg  <= 1'b1;
                        state_reg   <= S_DDONE;
                    end
                end
                S_IFETCH: begin
                    if (access_done) begin
                        if_rdata_reg <= rdata_in;
                        if_valid_reg <= 1'b1;
                        mem_req_reg  <= 1'b0;
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // DDONE is the one cycle the pipeline is released to consume the data result.
    assign stall_o = ((state_reg == S_IDLE)   && d_access) ||
                      (state_reg == S_DATA) ||
                     ((state_reg == S_IFETCH) && d_access);

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_be    = mem_be_reg;
    assign if_valid      = if_valid_reg;
    assign if_rdata      = if_rdata_reg;
    assign d_done        = d_done_reg;
    assign d_rdata       = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; covers the timeout path when
// MEM_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES overridden to 8).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_store_type = 2'b00;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        stall_o;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if mem ();

`ifdef MEM_ARB_TIMEOUT_EN
    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
`else
    mem_port_arbiter dut (
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_store_type (d_store_type),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .stall_o      (stall_o),
        .mem          (mem.master),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;

        // Reset state
        #12;
        chk("rst_mem_req", mem.mem_req, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_mem_be", mem.mem_be, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset: mem_req=%0b stall=%0b", mem.mem_req, stall_o);

        // Byte store to 0x1003, two wait states
        d_write = 1'b1; d_addr = 32'h1003; d_store_type = ST_BYTE; d_wdata = 32'h0000_00AB;
        #1 chk("sb_stall_c0", stall_o, 1);
        tick();
        chk("sb_mem_req", mem.mem_req, 1);
        chk("sb_mem_we", mem.mem_we, 1);
        chk("sb_mem_be", mem.mem_be, 4'b1000);
        chk("sb_mem_wdata", mem.mem_wdata, 32'hABABABAB);
        chk("sb_mem_addr", mem.mem_addr, 32'h1000);
        chk("sb_stall_c1", stall_o, 1);
        tick();
        chk("sb_stall_c2", stall_o, 1);
        chk("sb_done_c2", d_done, 0);
        mem.mem_ready = 1'b1;
        #1 chk("sb_stall_c3", stall_o, 1);
        tick();
        mem.mem_ready = 1'b0;
        chk("sb_done_c4", d_done, 1);
        chk("sb_stall_c4", stall_o, 0);
        chk("sb_req_c4", mem.mem_req, 0);
        tick();
        d_write = 1'b0;
        #1 chk("sb_done_c5", d_done, 0);
        $display("store byte: be=%b wdata=%h", mem.mem_be, mem.mem_wdata);

        // Stray mem_ready while idle is ignored
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h5555_5555;
        tick();
        mem.mem_ready = 1'b0;
        chk("stray_req", mem.mem_req, 0);
        chk("stray_done", d_done, 0);
        chk("stray_ifv", if_valid, 0);
        $display("stray ready: ignored");

        // Half store to upper lane, zero wait states
        d_write = 1'b1; d_addr = 32'h2002; d_store_type = ST_HALF; d_wdata = 32'h0000_BEEF;
        tick();
        chk("sh_mem_be", mem.mem_be, 4'b1100);
        chk("sh_mem_wdata", mem.mem_wdata, 32'hBEEFBEEF);
        chk("sh_mem_addr", mem.mem_addr, 32'h2000);
        mem.mem_ready = 1'b1;
        tick();
        mem.mem_ready = 1'b0;
        chk("sh_done", d_done, 1);
        tick();
        d_write = 1'b0;
        $display("store half: be=%b wdata=%h", 4'b1100, 32'hBEEFBEEF);

        // Collision: load and fetch together, data first
        if_req = 1'b1; if_addr = 32'h400; d_read = 1'b1; d_addr = 32'h3006;
        tick();
        chk("col_we", mem.mem_we, 0);
        chk("col_be", mem.mem_be, 4'b1111);
        chk("col_addr", mem.mem_addr, 32'h3004);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
        tick();
        mem.mem_ready = 1'b0;
        chk("col_done", d_done, 1);
        chk("col_rdata", d_rdata, 32'hCAFEF00D);
        chk("col_ifv_early", if_valid, 0);
        tick();
        d_read = 1'b0;
        chk("col_req_idle", mem.mem_req, 0);
        tick();
        chk("col_f_req", mem.mem_req, 1);
        chk("col_f_addr", mem.mem_addr, 32'h400);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h600DF00D;
        tick();
        mem.mem_ready = 1'b0;
        chk("col_ifv", if_valid, 1);
        chk("col_if_rdata", if_rdata, 32'h600DF00D);
        chk("col_b2b_gap", mem.mem_req, 0);
        if_addr = 32'h404;
        tick();
        chk("col_b2b_req", mem.mem_req, 1);
        chk("col_b2b_addr", mem.mem_addr, 32'h404);
        chk("col_ifv_pulse", if_valid, 0);
        mem.mem_ready = 1'b1;
        tick();
        mem.mem_ready = 1'b0;
        if_req = 1'b0;
        tick();
        $display("collision: data then fetch ok");

        // Reset in the middle of a data access
        d_read = 1'b1; d_addr = 32'h5000;
        tick();
        chk("rma_req_before", mem.mem_req, 1);
        d_read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rma_req", mem.mem_req, 0);
        chk("rma_stall", stall_o, 0);
        chk("rma_done", d_done, 0);
        chk("rma_rdata", d_rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rma_idle_req", mem.mem_req, 0);
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        chk("rma_fetch_req", mem.mem_req, 1);
        chk("rma_fetch_addr", mem.mem_addr, 32'h700);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h7;
        tick();
        mem.mem_ready = 1'b0; if_req = 1'b0;
        chk("rma_fetch_ifv", if_valid, 1);
        tick();
        $display("reset mid-access: abandoned");

        // Load arrives during a 3-wait-state fetch
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        chk("lf_req", mem.mem_req, 1);
        chk("lf_stall_c1", stall_o, 0);
        tick();
        d_read = 1'b1; d_addr = 32'h4000;
        #1 chk("lf_stall_c2", stall_o, 1);
        tick();
        chk("lf_stall_c3", stall_o, 1);
        chk("lf_addr_stable", mem.mem_addr, 32'h500);
        tick();
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h1111_1111;
        tick();
        mem.mem_ready = 1'b0;
        if_req = 1'b0;
        chk("lf_ifv", if_valid, 1);
        chk("lf_if_rdata", if_rdata, 32'h1111_1111);
        chk("lf_stall_c5", stall_o, 1);
        tick();
        chk("lf_d_req", mem.mem_req, 1);
        chk("lf_d_addr", mem.mem_addr, 32'h4000);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h12345678;
        tick();
        mem.mem_ready = 1'b0;
        chk("lf_done", d_done, 1);
        chk("lf_rdata", d_rdata, 32'h12345678);
        chk("lf_stall_ddone", stall_o, 0);
        tick();
        d_read = 1'b0;
        $display("load during fetch: d_rdata=%h", d_rdata);

        // Memory that never answers
        mem.mem_rdata = 32'hFFFF_FFFF;
        d_read = 1'b1; d_addr = 32'h6000;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("to_req_c%0d", i), mem.mem_req, 1);
        end
        chk("to_no_done_early", d_done, 0);
        tick();
        chk("to_done", d_done, 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_err", timeout_err, 1);
        chk("to_req_drop", mem.mem_req, 0);
        tick();
        d_read = 1'b0;
        tick();
        chk("to_err_sticky", timeout_err, 1);
        $display("timeout: forced completion, err=%0b", timeout_err);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nt_req_held", mem.mem_req, 1);
        chk("nt_no_done", d_done, 0);
        chk("nt_stall", stall_o, 1);
        chk("nt_err", timeout_err, 0);
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h0BADCAFE;
        tick();
        mem.mem_ready = 1'b0;
        chk("nt_done", d_done, 1);
        chk("nt_rdata", d_rdata, 32'h0BADCAFE);
        tick();
        d_read = 1'b0;
        $display("no timeout: waited for mem_ready");
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
